remodel_sram_req_adapter: RTL and testbench

Single-port front-end placed directly upstream of one port of `remodel_tc_sram`. It converts a valid/ready request stream into the macro's fire-and-forget `req/we/addr/wdata/be` port. It tracks the macro's fixed read latency and captures read data into a response FIFO, so a consumer that stalls never loses data. Out-of-range addresses are blocked before they reach the macro. Multi-port SRAMs use one instance per port.

---
 rtl/remodel_mem_pkg.sv | 21 ++
 rtl/remodel_rsp_fifo.sv | 46 ++++
 rtl/remodel_sram_req_adapter.sv | 110 +++++++++++
 tb/tb_remodel_sram_req_adapter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/remodel_mem_pkg.sv
// Shared types, limits and width helpers for the remodel SRAM front-end.
package remodel_mem_pkg;

  localparam int unsigned MaxLatency   = 8;
  localparam int unsigned DefDataWidth = 128;

  typedef struct packed {
    logic [DefDataWidth-1:0] rdata;
    logic                    err;
  } rsp_t;

  function automatic int unsigned calc_addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  function automatic int unsigned calc_be_width(input int unsigned data_w,
                                                input int unsigned byte_w);
    return (data_w + byte_w - 1) / byte_w;
  endfunction

endpackage

// File: rtl/remodel_rsp_fifo.sv
// Response FIFO with registered output; simultaneous push and pop are both honoured.
module remodel_rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T              r_mem [Depth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (pop_i) r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
      r_cnt <= r_cnt + CntW'(push_i) - CntW'(pop_i);
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/remodel_sram_req_adapter.sv
// Valid/ready front-end for one fixed-latency SRAM port: range check, read tag
// pipeline and a response FIFO sized so that accepted reads can never be lost.
module remodel_sram_req_adapter
  import remodel_mem_pkg::*;
#(
  parameter  int unsigned NumWords  = 1024,
  parameter  int unsigned DataWidth = 128,
  parameter  int unsigned ByteWidth = 8,
  parameter  int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = calc_addr_width(NumWords),
  localparam int unsigned BeWidth   = calc_be_width(DataWidth, ByteWidth),
  localparam int unsigned RspDepth  = Latency + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [31:0]          req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntW = $clog2(RspDepth + 1);

  if (Latency < 1 || Latency > MaxLatency) begin : g_bad_latency
    $error("remodel_sram_req_adapter: Latency must be within 1..MaxLatency");
  end

  // Same layout as rsp_t, sized to this instance's data width.
  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } rsp_port_t;

  logic [CntW-1:0]    r_cnt;
  logic [Latency-1:0] r_tag_vld;
  logic [Latency-1:0] r_tag_err;

  logic      w_in_range, w_acc, w_rd_acc, w_pop, w_push;
  logic      w_fifo_full, w_fifo_empty;
  rsp_port_t w_push_rsp, w_head_rsp;

  assign w_in_range  = (req_addr_i < 32'(NumWords));
  assign w_pop       = ~w_fifo_empty & rsp_ready_i;
  assign req_ready_o = (r_cnt < CntW'(RspDepth)) | w_pop;
  assign w_acc       = req_valid_i & req_ready_o;
  assign w_rd_acc    = w_acc & ~req_we_i;

  assign sram_req_o   = w_acc & w_in_range;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i[AddrWidth-1:0];
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  // Counts reads still owed a FIFO slot, so the FIFO can never overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else         r_cnt <= r_cnt + CntW'(w_rd_acc) - CntW'(w_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tag_vld <= '0;
      r_tag_err <= '0;
    end else begin
      r_tag_vld[0] <= w_rd_acc;
      r_tag_err[0] <= ~w_in_range;
      for (int i = 1; i < int'(Latency); i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_err[i] <= r_tag_err[i-1];
      end
    end
  end

  assign w_push           = r_tag_vld[Latency-1];
  assign w_push_rsp.err   = r_tag_err[Latency-1];
  assign w_push_rsp.rdata = r_tag_err[Latency-1] ? '0 : sram_rdata_i;

  remodel_rsp_fifo #(
    .Depth (RspDepth),
    .T     (rsp_port_t)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_push_rsp),
    .pop_i   (w_pop),
    .data_o  (w_head_rsp),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign rsp_valid_o = ~w_fifo_empty;
  assign rsp_rdata_o = w_head_rsp.rdata;
  assign rsp_err_o   = w_head_rsp.err;

  a_push_room: assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_push && w_fifo_full));

endmodule

// File: tb/tb_remodel_sram_req_adapter.sv
// Directed bench for remodel_sram_req_adapter with a 2-cycle behavioural SRAM behind it.
module tb_remodel_sram_req_adapter;

  localparam int NW  = 1024;
  localparam int DW  = 128;
  localparam int BW  = 16;
  localparam int LAT = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [31:0]   req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic [BW-1:0] req_be_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [9:0]    sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [BW-1:0] sram_be_o;
  logic [DW-1:0] sram_rdata_i;

  int checks = 0;
  int failures = 0;

  remodel_sram_req_adapter #(
    .NumWords  (NW),
    .DataWidth (DW),
    .ByteWidth (8),
    .Latency   (LAT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_be_i     (req_be_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
    .sram_rdata_i (sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] pat(input int a);
    return {4{32'hC0DE_0000 + 32'(a)}};
  endfunction

  // Behavioural SRAM: write at the request edge, read data LAT cycles later.
  logic          mem_init = 1'b1;
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] rdq [LAT];

  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) mem[i] <= pat(i);
    end else if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < BW; b++)
          if (sram_be_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      end else begin
        rdq[0] <= mem[sram_addr_o];
      end
    end
    for (int i = 1; i < LAT; i++) rdq[i] <= rdq[i-1];
  end
  assign sram_rdata_i = rdq[LAT-1];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input int addr, input logic [DW-1:0] wd,
                       input logic [BW-1:0] be, output logic sreq);
    int n;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = 32'(addr);
    req_wdata_i = wd;
    req_be_i    = be;
    #1;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!req_ready_o) begin
      checks++;
      failures++;
      $error("FAIL accept_timeout observed=ready_low expected=ready_high addr=%0d", addr);
    end
    sreq = sram_req_o;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
  endtask

  // Read with rsp_ready_i high: response must appear exactly LAT+1 cycles after accept.
  task automatic read_check(input string tag, input int addr, input logic [DW-1:0] exp_data,
                            input logic exp_err, input logic exp_sreq);
    logic s;
    issue(1'b0, addr, '0, '0, s);
    chk({tag, "_sreq"}, DW'(s), DW'(exp_sreq));
    chk({tag, "_early1"}, DW'(rsp_valid_o), DW'(0));
    @(negedge clk_i);
    chk({tag, "_early2"}, DW'(rsp_valid_o), DW'(0));
    @(negedge clk_i);
    chk({tag, "_valid"}, DW'(rsp_valid_o), DW'(1));
    chk({tag, "_data"}, rsp_rdata_o, exp_data);
    chk({tag, "_err"}, DW'(rsp_err_o), DW'(exp_err));
    @(negedge clk_i);
  endtask

  initial begin
    logic s;
    int   rcv, acc_n, stale;

    // Reset state
    @(posedge clk_i);
    #1 mem_init = 1'b0;
    @(negedge clk_i);
    chk("rst_valid", DW'(rsp_valid_o), DW'(0));
    chk("rst_err",   DW'(rsp_err_o),   DW'(0));
    chk("rst_rdata", rsp_rdata_o,      DW'(0));
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", DW'(req_ready_o), DW'(1));

    // Write then immediately read back
    issue(1'b1, 5, {16{8'hA5}}, '1, s);
    chk("wr_sreq", DW'(s), DW'(1));
    read_check("wr_rd", 5, {16{8'hA5}}, 1'b0, 1'b1);

    // Streaming: 16 back-to-back reads, one response per cycle
    rcv = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 16) begin
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'(16 + k);
        #1;
        chk("stream_ready", DW'(req_ready_o), DW'(1));
      end else begin
        req_valid_i = 1'b0;
        #1;
      end
      if (rsp_valid_o) begin
        chk("stream_data",  rsp_rdata_o, pat(16 + rcv));
        chk("stream_cycle", DW'(k), DW'(rcv + 3));
        rcv++;
      end
      @(posedge clk_i);
      @(negedge clk_i);
    end
    chk("stream_count", DW'(rcv), DW'(16));

    // Stall: only RspDepth reads accepted, then drain in order
    rsp_ready_i = 1'b0;
    acc_n = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = 32'(40 + acc_n);
      #1;
      if (req_ready_o) acc_n++;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    req_valid_i = 1'b0;
    chk("stall_accepts",  DW'(acc_n),       DW'(LAT + 1));
    chk("stall_ready_lo", DW'(req_ready_o), DW'(0));
    rsp_ready_i = 1'b1;
    #1;
    chk("stall_ready_rise", DW'(req_ready_o), DW'(1));
    rcv = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid_o) begin
        chk("drain_data", rsp_rdata_o, pat(40 + rcv));
        chk("drain_err",  DW'(rsp_err_o), DW'(0));
        rcv++;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
    end
    chk("drain_count", DW'(rcv), DW'(LAT + 1));

    // Out of range read and write
    read_check("oor_rd", NW, '0, 1'b1, 1'b0);
    issue(1'b1, NW + 3, {16{8'hDE}}, '1, s);
    chk("oor_wr_sreq", DW'(s), DW'(0));
    read_check("oor_wr_rb", 3, pat(3), 1'b0, 1'b1);

    // Byte enables
    issue(1'b1, 7, '1, '1, s);
    issue(1'b1, 7, '0, 16'h0001, s);
    read_check("be", 7, {{15{8'hFF}}, 8'h00}, 1'b0, 1'b1);

    // Reset with two reads in flight
    issue(1'b0, 50, '0, '0, s);
    issue(1'b0, 51, '0, '0, s);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(rsp_valid_o), DW'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("mid_rel_valid", DW'(rsp_valid_o), DW'(0));
    chk("mid_rel_ready", DW'(req_ready_o), DW'(1));
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o) stale++;
    end
    chk("mid_stale", DW'(stale), DW'(0));
    read_check("post_rst", 5, {16{8'hA5}}, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
